// File: rtl/cpu4_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : cpu4_ram_dp
// Brief    : Dual-port RAM for cpu4. Port A is read/write (data), port B is
//            read-only (fetch). Optional INIT_VALUE clear sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
module cpu4_ram_dp #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wen_a,
  input  logic                  ren_a,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic                  q_a_valid,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  ren_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  q_b_valid,
  output logic                  busy
);

  localparam int c_depth = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_clr_we;
  logic                  w_ready;
  logic                  w_user_we;
  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clr_we) begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  // Without a sweep, CLEAR still lasts one cycle so busy always pulses after reset.
  always_comb begin
    w_state_next = r_state;
    w_clr_we     = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          w_clr_we = 1'b1;
          if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
            w_state_next = ST_READY;
          end
        end else begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_next = ST_CLEAR;
      end
    endcase
  end

  assign busy      = (r_state == ST_CLEAR);
  assign w_user_we = w_ready && wen_a && !reset;

  // Storage is deliberately not reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (w_clr_we && !reset) begin
      r_mem[r_clr_addr] <= INIT_VALUE;
    end else if (w_user_we) begin
      r_mem[address_a] <= data_a;
    end
  end

  // Port B reads the pre-write word on an A/B address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_a       <= '0;
      q_b       <= '0;
      q_a_valid <= 1'b0;
      q_b_valid <= 1'b0;
    end else if (w_ready) begin
      q_a_valid <= ren_a;
      q_b_valid <= ren_b;
      if (ren_a) begin
        q_a <= wen_a ? data_a : r_mem[address_a];
      end
      if (ren_b) begin
        q_b <= r_mem[address_b];
      end
    end else begin
      q_a_valid <= 1'b0;
      q_b_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu4_ram_dp.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu4_ram_dp
// Brief    : Self-checking bench: instance 0 sweeps on reset, instance 1 keeps
//            contents; both are compared each cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu4_ram_dp;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [3:0] address_a, address_b;
  logic [7:0] data_a;
  logic       wen_a, ren_a, ren_b;

  logic [7:0] q_a0, q_b0, q_a1, q_b1;
  logic       va0, vb0, busy0, va1, vb1, busy1;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cpu4_ram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1), .INIT_VALUE(8'h5A)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .address_a(address_a), .data_a(data_a), .wen_a(wen_a), .ren_a(ren_a),
    .q_a(q_a0), .q_a_valid(va0),
    .address_b(address_b), .ren_b(ren_b),
    .q_b(q_b0), .q_b_valid(vb0), .busy(busy0)
  );

  cpu4_ram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0), .INIT_VALUE(8'h5A)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .address_a(address_a), .data_a(data_a), .wen_a(wen_a), .ren_a(ren_a),
    .q_a(q_a1), .q_a_valid(va1),
    .address_b(address_b), .ren_b(ren_b),
    .q_b(q_b1), .q_b_valid(vb1), .busy(busy1)
  );

  // Behavioural model: a word array per instance plus a countdown of busy cycles.
  logic [7:0] m_mem   [2][16];
  logic       m_known [2][16];
  int         m_left  [2];
  logic [7:0] m_qa [2], m_qb [2];
  logic       m_va [2], m_vb [2], m_qa_k [2], m_qb_k [2], m_started [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_started[i] = 1'b0;
      m_left[i]    = 0;
      m_qa_k[i]    = 1'b0;
      m_qb_k[i]    = 1'b0;
      for (int a = 0; a < 16; a++) m_known[i][a] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_started[i] <= 1'b1;
        m_left[i]    <= (i == 0) ? 16 : 1;
        m_qa[i] <= 8'h00; m_qb[i] <= 8'h00;
        m_va[i] <= 1'b0;  m_vb[i] <= 1'b0;
        m_qa_k[i] <= 1'b1; m_qb_k[i] <= 1'b1;
      end else if (m_left[i] != 0) begin
        if (i == 0) begin
          m_mem[i][16 - m_left[i]]   <= 8'h5A;
          m_known[i][16 - m_left[i]] <= 1'b1;
        end
        m_left[i] <= m_left[i] - 1;
        m_va[i] <= 1'b0;
        m_vb[i] <= 1'b0;
      end else begin
        m_va[i] <= ren_a;
        m_vb[i] <= ren_b;
        if (ren_a) begin
          m_qa[i]   <= wen_a ? data_a : m_mem[i][address_a];
          m_qa_k[i] <= wen_a ? 1'b1 : m_known[i][address_a];
        end
        if (ren_b) begin
          m_qb[i]   <= m_mem[i][address_b];
          m_qb_k[i] <= m_known[i][address_b];
        end
        if (wen_a) begin
          m_mem[i][address_a]   <= data_a;
          m_known[i][address_a] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_started[i]) begin
        check($sformatf("busy%0d", i), {31'd0, (i == 0) ? busy0 : busy1}, {31'd0, m_left[i] != 0});
        check($sformatf("q_a_valid%0d", i), {31'd0, (i == 0) ? va0 : va1}, {31'd0, m_va[i]});
        check($sformatf("q_b_valid%0d", i), {31'd0, (i == 0) ? vb0 : vb1}, {31'd0, m_vb[i]});
        if (m_qa_k[i]) check($sformatf("q_a%0d", i), {24'd0, (i == 0) ? q_a0 : q_a1}, {24'd0, m_qa[i]});
        if (m_qb_k[i]) check($sformatf("q_b%0d", i), {24'd0, (i == 0) ? q_b0 : q_b1}, {24'd0, m_qb[i]});
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    wen_a = 1'b0; ren_a = 1'b0; ren_b = 1'b0;
  endtask

  task automatic count_busy(input int which, output int n);
    n = 0;
    while (((which == 0) ? busy0 : busy1) && n < 100) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    idle();
    address_a = '0; address_b = '0; data_a = '0;
    rst = 2'b11;
    step(); step();
    rst = 2'b00;
    count_busy(0, n);
    check("clear_busy_cycles", n, 16);

    for (int a = 0; a < 16; a++) begin
      ren_b = 1'b1; address_b = 4'(a);
      step();
      check("clear_read_b", {24'd0, q_b0}, 32'h5A);
      check("clear_read_b_valid", {31'd0, vb0}, 1);
    end
    idle(); step();

    wen_a = 1'b1; address_a = 4'd0;  data_a = 8'hAA; step();
    address_a = 4'd15; data_a = 8'h3C; step();
    wen_a = 1'b0; ren_a = 1'b1; address_a = 4'd0; step();
    check("rd_a_addr0", {24'd0, q_a0}, 32'hAA);
    check("rd_a_addr0_valid", {31'd0, va0}, 1);
    address_a = 4'd15; step();
    check("rd_a_addr15", {24'd0, q_a0}, 32'h3C);
    check("rd_a_addr15_valid", {31'd0, va0}, 1);
    idle(); step();
    check("rd_a_valid_drop", {31'd0, va0}, 0);
    check("rd_a_hold", {24'd0, q_a0}, 32'h3C);

    wen_a = 1'b1; ren_a = 1'b1; address_a = 4'd4; data_a = 8'h77; step();
    check("write_first", {24'd0, q_a0}, 32'h77);
    check("write_first_valid", {31'd0, va0}, 1);
    idle();

    wen_a = 1'b1; address_a = 4'd7; data_a = 8'h11; ren_b = 1'b1; address_b = 4'd7; step();
    check("collision_old", {24'd0, q_b0}, 32'h5A);
    wen_a = 1'b0; step();
    check("collision_new", {24'd0, q_b0}, 32'h11);
    idle(); step();

    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    for (int c = 1; c < 5; c++) step();
    wen_a = 1'b1; address_a = 4'd2; data_a = 8'hFF; ren_b = 1'b1; address_b = 4'd2; step();
    check("busy_no_valid_b", {31'd0, vb0}, 0);
    idle(); step(); step();
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    count_busy(0, n);
    check("resweep_busy_cycles", n, 16);
    ren_a = 1'b1; address_a = 4'd2; step();
    check("resweep_addr2", {24'd0, q_a0}, 32'h5A);
    idle(); step();

    wen_a = 1'b1; address_a = 4'd9; data_a = 8'hC3; step();
    idle();
    rst[1] = 1'b1; step(); rst[1] = 1'b0;
    count_busy(1, n);
    check("noclear_busy_cycles", n, 1);
    ren_a = 1'b1; address_a = 4'd9; step();
    check("noclear_keep", {24'd0, q_a1}, 32'hC3);
    check("noclear_keep_valid", {31'd0, va1}, 1);
    idle(); step();

    for (int k = 0; k < 600; k++) begin
      wen_a     = ($urandom_range(0, 2) == 0);
      ren_a     = $urandom_range(0, 1) == 1;
      ren_b     = $urandom_range(0, 1) == 1;
      address_a = 4'($urandom_range(0, 15));
      address_b = ($urandom_range(0, 3) == 0) ? address_a : 4'($urandom_range(0, 15));
      data_a    = 8'($urandom);
      rst[0]    = ($urandom_range(0, 199) == 0);
      rst[1]    = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 2'b00; idle();
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
